// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-stage branch predictor:
// 2-bit saturating counter encoding and the conditional-branch opcode.
package bp_pkg;

  typedef logic [1:0] bp_cnt_t;

  localparam bp_cnt_t BP_SNT = 2'b00;
  localparam bp_cnt_t BP_WNT = 2'b01;
  localparam bp_cnt_t BP_WT  = 2'b10;
  localparam bp_cnt_t BP_ST  = 2'b11;

  localparam bp_cnt_t BP_CNT_RESET = BP_WNT;

  localparam logic [6:0] BP_OPC_BRANCH = 7'b1100011;

  function automatic bp_cnt_t bp_cnt_next(input bp_cnt_t cnt, input logic taken);
    bp_cnt_t nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != BP_ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != BP_SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational hit/target read port,
// synchronous write port. Only valid bits are reset; tags/targets are don't-care.
module bp_btb
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  input  logic [TAG_BITS-1:0]   rd_tag_i,
  output logic                  rd_hit_o,
  output logic [31:0]           rd_target_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [31:0]           wr_target_i
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic [DEPTH-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q    [DEPTH];
  logic [31:0]         target_q [DEPTH];

  assign rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_target_o = target_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; a write coinciding with reset is dropped
  // so the entry is never left half-written.
  always_ff @(posedge clk) begin
    if (rstn && wr_en_i) begin
      tag_q[wr_idx_i]    <= wr_tag_i;
      target_q[wr_idx_i] <= wr_target_i;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage bimodal predictor (2-bit counters + PC-indexed BTB).
// Define BP_GSHARE_EN to XOR a non-speculative global history into the counter index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [31:0]           pc,
  output logic                  pred_taken,
  output logic [31:0]           pred_target,
  output logic [INDEX_BITS-1:0] pred_idx,
  input  logic                  upd_valid,
  input  logic                  upd_taken,
  input  logic [31:0]           upd_pc,
  input  logic [31:0]           upd_target,
  input  logic [INDEX_BITS-1:0] upd_idx
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int DEPTH    = 1 << INDEX_BITS;

  logic [INDEX_BITS-1:0] pc_idx;
  logic [TAG_BITS-1:0]   pc_tag;
  logic [INDEX_BITS-1:0] upd_pc_idx;
  logic [TAG_BITS-1:0]   upd_pc_tag;
  logic                  btb_hit;
  logic [31:0]           btb_target;
  logic                  unused_pc_bits;

  bp_cnt_t cnt_q [DEPTH];

  assign pc_idx         = pc[INDEX_BITS+1:2];
  assign pc_tag         = pc[31:INDEX_BITS+2];
  assign upd_pc_idx     = upd_pc[INDEX_BITS+1:2];
  assign upd_pc_tag     = upd_pc[31:INDEX_BITS+2];
  assign unused_pc_bits = ^{pc[1:0], upd_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q;
  logic [INDEX_BITS-1:0] ghr_d;

  assign ghr_d    = {ghr_q[INDEX_BITS-2:0], upd_taken};
  assign pred_idx = pc_idx ^ ghr_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ghr_q <= '0;
    end else if (upd_valid) begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign pred_idx = pc_idx;
`endif

  bp_btb #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_btb (
    .clk        (clk),
    .rstn       (rstn),
    .rd_idx_i   (pc_idx),
    .rd_tag_i   (pc_tag),
    .rd_hit_o   (btb_hit),
    .rd_target_o(btb_target),
    .wr_en_i    (upd_valid && upd_taken),
    .wr_idx_i   (upd_pc_idx),
    .wr_tag_i   (upd_pc_tag),
    .wr_target_i(upd_target)
  );

  // No bypass: a same-cycle update at this entry is only seen next cycle.
  assign pred_taken  = btb_hit && cnt_q[pred_idx][1];
  assign pred_target = pred_taken ? btb_target : (pc + 32'd4);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= BP_CNT_RESET;
    end else if (upd_valid) begin
      cnt_q[upd_idx] <= bp_cnt_next(cnt_q[upd_idx], upd_taken);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a table model.
module tb_branch_predictor;

  localparam int IB    = 6;
  localparam int DEPTH = 1 << IB;

  logic          clk;
  logic          rstn;
  logic [31:0]   pc;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic [IB-1:0] pred_idx;
  logic          upd_valid;
  logic          upd_taken;
  logic [31:0]   upd_pc;
  logic [31:0]   upd_target;
  logic [IB-1:0] upd_idx;

  int checks   = 0;
  int failures = 0;
  bit model_chk = 0;

  // Reference state: counter as an integer 0..3, BTB as plain arrays.
  int          m_cnt [DEPTH];
  bit          m_vld [DEPTH];
  logic [23:0] m_tag [DEPTH];
  logic [31:0] m_tgt [DEPTH];
  int          m_ghr;

  branch_predictor #(.INDEX_BITS(IB)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pc         (pc),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .pred_idx   (pred_idx),
    .upd_valid  (upd_valid),
    .upd_taken  (upd_taken),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_idx    (upd_idx)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic int model_pidx(input logic [31:0] a);
`ifdef BP_GSHARE_EN
    return idx_of(a) ^ m_ghr;
`else
    return idx_of(a);
`endif
  endfunction

  // Model update at each edge, from inputs held stable since #1 after the previous edge.
  always @(posedge clk) begin
    if (rstn !== 1'b1) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_cnt[i] = 1;
        m_vld[i] = 0;
      end
      m_ghr = 0;
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (m_cnt[upd_idx] < 3) m_cnt[upd_idx] = m_cnt[upd_idx] + 1;
        m_vld[idx_of(upd_pc)] = 1;
        m_tag[idx_of(upd_pc)] = upd_pc[31:8];
        m_tgt[idx_of(upd_pc)] = upd_target;
      end else begin
        if (m_cnt[upd_idx] > 0) m_cnt[upd_idx] = m_cnt[upd_idx] - 1;
      end
      m_ghr = ((m_ghr * 2) + (upd_taken ? 1 : 0)) % DEPTH;
    end
  end

  always @(negedge clk) begin
    if (model_chk) begin
      int  i;
      int  pi;
      bit  hit;
      bit  tk;
      i   = idx_of(pc);
      pi  = model_pidx(pc);
      hit = m_vld[i] && (m_tag[i] == pc[31:8]);
      tk  = hit && (m_cnt[pi] >= 2);
      check("model_pred_idx", 32'(pred_idx), 32'(pi));
      check("model_pred_taken", 32'(pred_taken), 32'(tk));
      check("model_pred_target", pred_target, tk ? m_tgt[i] : pc + 32'd4);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input bit v, input bit t, input logic [31:0] a, input logic [31:0] tg);
    upd_valid  = v;
    upd_taken  = t;
    upd_pc     = a;
    upd_target = tg;
    upd_idx    = IB'(idx_of(a));
  endtask

  initial begin
    rstn = 0;
    pc   = 32'h100;
    set_upd(0, 0, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    rstn = 1;
    model_chk = 1;
    @(negedge clk);
    check("s1_taken", 32'(pred_taken), 32'd0);
    check("s1_target", pred_target, 32'h104);
    check("s1_idx", 32'(pred_idx), 32'd0);

`ifndef BP_GSHARE_EN
    // Scenario 2 + same-cycle hazard.
    next_cycle();
    set_upd(1, 1, 32'h100, 32'h80);
    @(negedge clk);
    check("s5_same_cycle_taken", 32'(pred_taken), 32'd0);
    next_cycle();
    set_upd(0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("s2_taken", 32'(pred_taken), 32'd1);
    check("s2_target", pred_target, 32'h80);

    // Saturation: counter climbs to 11, then two not-taken steps.
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      set_upd(1, 1, 32'h100, 32'h80);
    end
    next_cycle();
    set_upd(1, 0, 32'h100, 32'h0);
    next_cycle();
    set_upd(0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("s3_one_nt_taken", 32'(pred_taken), 32'd1);
    next_cycle();
    set_upd(1, 0, 32'h100, 32'h0);
    next_cycle();
    set_upd(0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("s3_two_nt_taken", 32'(pred_taken), 32'd0);
    check("s3_two_nt_target", pred_target, 32'h104);

    // Aliasing: same index, different tag.
    next_cycle();
    set_upd(1, 1, 32'h100, 32'h80);
    next_cycle();
    set_upd(0, 0, 32'h0, 32'h0);
    pc = 32'h200;
    @(negedge clk);
    check("s4_alias_taken", 32'(pred_taken), 32'd0);
    check("s4_alias_target", pred_target, 32'h204);
    next_cycle();
    pc = 32'h100;
    @(negedge clk);
    check("s4_owner_taken", 32'(pred_taken), 32'd1);
`else
    next_cycle();
    set_upd(1, 1, 32'h100, 32'h80);
    next_cycle();
    set_upd(1, 1, 32'h140, 32'h40);
    next_cycle();
    set_upd(0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("gs_idx_after_history", 32'(pred_idx), 32'd3);
`endif

    // Reset together with an active update discards everything.
    next_cycle();
    pc = 32'h100;
    set_upd(1, 1, 32'h100, 32'h80);
    rstn = 0;
    next_cycle();
    rstn = 1;
    set_upd(0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("s6_taken", 32'(pred_taken), 32'd0);
    check("s6_target", pred_target, 32'h104);
    check("s6_idx", 32'(pred_idx), 32'd0);

    // Randomized traffic over a small tag/index pool so hits and aliases are common.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      next_cycle();
      a = {22'($urandom_range(3, 0)), 2'b00, 4'($urandom_range(7, 0)), 2'($urandom)};
      a[31:8] = 24'($urandom_range(3, 0));
      a[7:2]  = 6'($urandom_range(7, 0));
      b = a;
      b[31:8] = 24'($urandom_range(3, 0));
      b[7:2]  = 6'($urandom_range(7, 0));
      pc = a;
      set_upd(($urandom_range(3, 0) != 0), ($urandom_range(2, 0) != 0), b, $urandom);
      if ($urandom_range(7, 0) == 0) upd_idx = IB'($urandom);
      rstn = ($urandom_range(199, 0) != 0);
    end
    next_cycle();
    rstn = 1;
    set_upd(0, 0, 32'h0, 32'h0);
    @(negedge clk);
    model_chk = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage dynamic branch predictor for the pipelined RV32I core, and the counterpart of the EX-stage branch condition evaluator. IF looks up the current PC and gets a predicted next PC in the same cycle. EX reports the resolved direction and target of each conditional branch back to it, which trains a table of 2-bit saturating counters and a direct-mapped branch target buffer (BTB).

## Interface
- `INDEX_BITS`, default 6: table depth is 2^INDEX_BITS entries; index = `pc[INDEX_BITS+1:2]`.
- `TAG_BITS`, fixed at 30-INDEX_BITS: BTB tag = `pc[31:INDEX_BITS+2]`.
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: reset, synchronous, active-low.
- `pc` input 32: IF-stage fetch address.
- `pred_taken` output 1: predicted taken (combinational).
- `pred_target` output 32: predicted next PC (combinational).
- `pred_idx` output INDEX_BITS: counter index used for this lookup; the pipeline carries it to EX.
- `upd_valid` input 1: EX resolved a conditional branch (opcode 1100011) this cycle.
- `upd_taken` input 1: resolved direction.
- `upd_pc` input 32: PC of the resolved branch.
- `upd_target` input 32: resolved taken target.
- `upd_idx` input INDEX_BITS: `pred_idx` carried from the branch's fetch.

## Operation
- State per entry:
  - 2-bit counter: 00 SNT, 01 WNT, 10 WT, 11 ST.
  - BTB valid bit, tag and 32-bit target.
- Lookup, combinational:
  - hit = `btb_valid[i] && btb_tag[i] == pc[31:INDEX_BITS+2]`, with i = PC index.
  - `pred_taken` = hit && `cnt[pred_idx][1]`.
  - `pred_target` = `btb_target[i]` if `pred_taken`, else `pc+4` (modulo 2^32).
- Update, on the rising edge with `upd_valid`=1:
  - `cnt[upd_idx]` increments if `upd_taken` (saturates at 11) and decrements otherwise (saturates at 00).
  - If `upd_taken`, the BTB entry at the index of `upd_pc` is overwritten with valid=1, the tag of `upd_pc` and `upd_target`.
  - A not-taken update never touches the BTB.
- `upd_valid`=0: no state change. `upd_*` are ignored.
- `pc` bits [1:0] are ignored.

## Timing
- Lookup latency is 0 cycles, purely combinational from `pc` and state.
- An update becomes visible to lookups from the cycle after its edge.
- Update and lookup of the same entry in the same cycle: the lookup sees pre-update state. There is no bypass.
- Reset (`rstn`=0 at an edge):
  - every counter goes to 01 and every BTB valid bit to 0; the GHR (if present) goes to 0.
  - Tags and targets are don't-care.
  - Outputs after reset: `pred_taken`=0, `pred_target`=`pc+4`, `pred_idx`=`pc[INDEX_BITS+1:2]`.
- Reset asserted in the same cycle as `upd_valid`: reset wins and the update is discarded.
- Reset mid-training discards all learned state.

## Configuration
- `BP_GSHARE_EN` defined:
  - An INDEX_BITS-wide global history register (GHR) is added.
  - `pred_idx` = `pc[INDEX_BITS+1:2] ^ ghr`.
  - On each `upd_valid` edge, `ghr <= {ghr[INDEX_BITS-2:0], upd_taken}`. The GHR is non-speculative.
  - The BTB stays PC-indexed.
- `BP_GSHARE_EN` undefined:
  - There is no GHR.
  - `pred_idx` = `pc[INDEX_BITS+1:2]`.

## Structure
- Package `bp_pkg` holds:
  - the counter-state constants `BP_SNT`/`BP_WNT`/`BP_WT`/`BP_ST`, with reset state `BP_WNT`;
  - the branch opcode constant 7'b1100011;
  - the 2-bit counter typedef.
- One sub-module, `bp_btb`, holds the valid/tag/target arrays with a combinational hit/target read port and a synchronous write port. The counter table and GHR stay in the top level.

## Test plan
All scenarios use INDEX_BITS=6 with `BP_GSHARE_EN` undefined unless stated.
1. Reset, then `pc`=0x100 → `pred_taken`=0, `pred_target`=0x104, `pred_idx`=0.
2. One update with `upd_pc`=0x100, `upd_idx`=0, taken, `upd_target`=0x80 → next cycle, `pc`=0x100 gives `pred_taken`=1, `pred_target`=0x80.
3. Saturation: four taken updates at 0x100, then one not-taken → still `pred_taken`=1 (state 10). A second not-taken → `pred_taken`=0, `pred_target`=0x104.
4. Aliasing: after training 0x100 taken, look up `pc`=0x200 (same index, different tag) → `pred_taken`=0, `pred_target`=0x204.
5. Same-cycle hazard: from reset, update 0x100 taken while looking up 0x100 in the same cycle → that cycle `pred_taken`=0; the next cycle `pred_taken`=1.
6. Reset mid-run: train as in scenario 2, pull `rstn` low for one edge together with an active update → `pred_taken`=0 for `pc`=0x100. With `BP_GSHARE_EN` defined, `pred_idx` for `pc`=0x100 is 0 again (GHR cleared).
